// File: rtl/vp_recovery_unit.sv
// vp_recovery_unit: responder side of the load value-prediction recovery handshake.
// Opens a speculative epoch on chk_start, logs the pre-write value of every
// register-file write in an undo log, discards it on commit, and on recover
// unwinds it newest-first through the restore port before pulsing recovery_done.
// Ports: clk/rst_n (sync, active-low); chk_start/chk_pc open an epoch;
// commit/recover resolve it; wb_valid/wb_reg/wb_old_data feed the log;
// spec_active/log_full/overflow_err report status; rf_restore_* drive the
// regfile restore port; recovery_done/redirect_valid/redirect_pc end recovery.
// Optional: VP_LOG_COALESCE_EN logs only the first write to each register per epoch.
module vp_recovery_unit #(
  parameter int LOG_DEPTH     = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     chk_start,
  input  logic [ADDR_WIDTH-1:0]    chk_pc,
  input  logic                     commit,
  input  logic                     recover,
  input  logic                     wb_valid,
  input  logic [REG_IDX_WIDTH-1:0] wb_reg,
  input  logic [DATA_WIDTH-1:0]    wb_old_data,
  output logic                     spec_active,
  output logic                     log_full,
  output logic                     overflow_err,
  output logic                     rf_restore_en,
  output logic [REG_IDX_WIDTH-1:0] rf_restore_reg,
  output logic [DATA_WIDTH-1:0]    rf_restore_data,
  output logic                     recovery_done,
  output logic                     redirect_valid,
  output logic [ADDR_WIDTH-1:0]    redirect_pc
);
  localparam int IW = $clog2(LOG_DEPTH);
  localparam int CW = IW + 1;
  typedef enum logic [1:0] {IDLE, SPEC, UNWIND, DONE} state_t;
  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    ovf_q, ovf_d;
  logic [REG_IDX_WIDTH-1:0] log_reg_q [LOG_DEPTH];
  logic [DATA_WIDTH-1:0]    log_data_q [LOG_DEPTH];
  logic                    full, is_new, push;
  logic [IW-1:0]           top_idx;
`ifdef VP_LOG_COALESCE_EN
  logic [2**REG_IDX_WIDTH-1:0] mask_q, mask_d;
  assign is_new = !mask_q[wb_reg];
`else
  assign is_new = 1'b1;
`endif
  assign full    = count_q == CW'(LOG_DEPTH);
  assign top_idx = IW'(count_q - 1'b1);
  assign push    = state_q == SPEC && wb_valid && wb_reg != '0 && !full && is_new;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pc_d    = pc_q;
    ovf_d   = ovf_q | (state_q == SPEC && wb_valid && full && is_new);
`ifdef VP_LOG_COALESCE_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      IDLE: if (chk_start) begin
        state_d = SPEC;
        pc_d    = chk_pc;
        count_d = '0;
`ifdef VP_LOG_COALESCE_EN
        mask_d  = '0;
`endif
      end
      SPEC: begin
        // A write in the recover cycle is pushed first so the unwind undoes it.
        if (push) begin
          count_d = count_q + 1'b1;
`ifdef VP_LOG_COALESCE_EN
          mask_d[wb_reg] = 1'b1;
`endif
        end
        if (recover) state_d = UNWIND;
        else if (commit) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      UNWIND: begin
        count_d = count_q != '0 ? count_q - 1'b1 : count_q;
        state_d = count_q <= CW'(1) ? DONE : UNWIND;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
`ifdef VP_LOG_COALESCE_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
`ifdef VP_LOG_COALESCE_EN
      mask_q  <= mask_d;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      log_reg_q[count_q[IW-1:0]]  <= wb_reg;
      log_data_q[count_q[IW-1:0]] <= wb_old_data;
    end
  end
  assign spec_active     = state_q == SPEC || state_q == UNWIND;
  assign log_full        = state_q == SPEC && full;
  assign overflow_err    = ovf_q;
  assign rf_restore_en   = state_q == UNWIND && count_q != '0;
  assign rf_restore_reg  = rf_restore_en ? log_reg_q[top_idx] : '0;
  assign rf_restore_data = rf_restore_en ? log_data_q[top_idx] : '0;
  assign recovery_done   = state_q == DONE;
  assign redirect_valid  = state_q == DONE;
  assign redirect_pc     = state_q == DONE ? pc_q : '0;
endmodule

// File: tb/tb_vp_recovery_unit.sv
// tb_vp_recovery_unit: directed and randomized epochs checked against a queue-based undo-log model.
module tb_vp_recovery_unit;
  localparam int DEPTH = 16;
`ifdef VP_LOG_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif
  typedef struct packed {logic [4:0] r; logic [31:0] d;} ent_t;
  logic clk = 1'b0, rst_n = 1'b0, chk_start = 1'b0, commit = 1'b0, recover = 1'b0, wb_valid = 1'b0;
  logic [31:0] chk_pc = '0, wb_old_data = '0;
  logic [4:0]  wb_reg = '0;
  logic spec_active, log_full, overflow_err, rf_restore_en, recovery_done, redirect_valid;
  logic [4:0]  rf_restore_reg;
  logic [31:0] rf_restore_data, redirect_pc;
  int total = 0, bad = 0;
  ent_t q[$];
  bit   ovf = 1'b0;
  bit   mask [32];
  logic [31:0] pc_lat = '0;
  vp_recovery_unit dut (
    .clk(clk), .rst_n(rst_n), .chk_start(chk_start), .chk_pc(chk_pc), .commit(commit),
    .recover(recover), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_old_data(wb_old_data),
    .spec_active(spec_active), .log_full(log_full), .overflow_err(overflow_err),
    .rf_restore_en(rf_restore_en), .rf_restore_reg(rf_restore_reg), .rf_restore_data(rf_restore_data),
    .recovery_done(recovery_done), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in();
    chk_start = 0; commit = 0; recover = 0; wb_valid = 0; wb_reg = '0; wb_old_data = '0;
  endtask
  task automatic model_write(input logic [4:0] r, input logic [31:0] d);
    bit fresh;
    fresh = !COAL || !mask[r];
    if (q.size() == DEPTH) begin
      if (fresh) ovf = 1'b1;
    end else if (r != 0 && fresh) begin
      q.push_back('{r: r, d: d});
      mask[r] = 1'b1;
    end
  endtask
  task automatic check_idle(input string tag);
    chk({tag, "_spec"}, spec_active, 0);
    chk({tag, "_full"}, log_full, 0);
    chk({tag, "_ren"}, rf_restore_en, 0);
    chk({tag, "_rreg"}, rf_restore_reg, 0);
    chk({tag, "_rdata"}, rf_restore_data, 0);
    chk({tag, "_done"}, recovery_done, 0);
    chk({tag, "_rvalid"}, redirect_valid, 0);
    chk({tag, "_rpc"}, redirect_pc, 0);
    chk({tag, "_ovf"}, overflow_err, ovf);
  endtask
  task automatic do_reset();
    clear_in();
    rst_n = 0;
    step();
    rst_n = 1;
    ovf = 1'b0;
    q.delete();
  endtask
  task automatic open_epoch(input logic [31:0] pc);
    chk_start = 1; chk_pc = pc;
    step();
    clear_in();
    q.delete();
    foreach (mask[i]) mask[i] = 1'b0;
    pc_lat = pc;
    chk("open_spec", spec_active, 1);
    chk("open_full", log_full, 0);
  endtask
  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1; wb_reg = r; wb_old_data = d;
    chk_start = 1'($urandom); chk_pc = $urandom;
    step();
    clear_in();
    model_write(r, d);
    chk("wr_spec", spec_active, 1);
    chk("wr_full", log_full, q.size() == DEPTH);
    chk("wr_ovf", overflow_err, ovf);
  endtask
  task automatic do_commit();
    commit = 1;
    step();
    clear_in();
    q.delete();
    check_idle("commit");
    step();
    check_idle("commit_after");
  endtask
  task automatic do_recover(input bit also_commit, input bit wb, input logic [4:0] r, input logic [31:0] d);
    ent_t e;
    recover = 1; commit = also_commit; wb_valid = wb; wb_reg = r; wb_old_data = d;
    step();
    clear_in();
    if (wb) model_write(r, d);
    if (q.size() == 0) begin
      chk("unw_none_en", rf_restore_en, 0);
      chk("unw_none_spec", spec_active, 1);
      step();
    end
    while (q.size() > 0) begin
      e = q.pop_back();
      chk("unw_en", rf_restore_en, 1);
      chk("unw_reg", rf_restore_reg, e.r);
      chk("unw_data", rf_restore_data, e.d);
      chk("unw_spec", spec_active, 1);
      chk("unw_done_early", recovery_done, 0);
      wb_valid = 1'($urandom); wb_reg = 5'($urandom); wb_old_data = $urandom;
      commit = 1'($urandom); recover = 1'($urandom); chk_start = 1'($urandom); chk_pc = $urandom;
      step();
      clear_in();
    end
    chk("done_pulse", recovery_done, 1);
    chk("done_rvalid", redirect_valid, 1);
    chk("done_rpc", redirect_pc, pc_lat);
    chk("done_spec", spec_active, 0);
    chk("done_ren", rf_restore_en, 0);
    chk("done_ovf", overflow_err, ovf);
    step();
    check_idle("post_done");
  endtask
  initial begin
    do_reset();
    step();
    check_idle("reset");
    commit = 1; recover = 1; wb_valid = 1; wb_reg = 5'd9;
    step();
    clear_in();
    check_idle("idle_ignore");
    open_epoch(32'h0040_0100);
    wr(5'd3, 32'h11);
    wr(5'd4, 32'h22);
    do_commit();
    open_epoch(32'h0040_0200);
    wr(5'd5, 32'hA);
    wr(5'd6, 32'hB);
    wr(5'd5, 32'hC);
    do_recover(0, 0, '0, '0);
    open_epoch(32'h0040_0300);
    do_recover(0, 0, '0, '0);
    open_epoch(32'h0040_0400);
    for (int i = 1; i <= 16; i++) wr(5'(i), 32'h1000 + 32'(i));
    chk("full_flag", log_full, 1);
    chk("full_no_ovf", overflow_err, 0);
    wr(5'd17, 32'hDEAD);
    chk("ovf_set", overflow_err, 1);
    do_recover(0, 0, '0, '0);
    chk("ovf_sticky", overflow_err, 1);
    open_epoch(32'h0040_0500);
    wr(5'd1, 32'h1);
    wr(5'd2, 32'h2);
    do_recover(1, 0, '0, '0);
    open_epoch(32'h0040_0600);
    wr(5'd8, 32'h88);
    wr(5'd0, 32'h99);
    do_recover(0, 1, 5'd7, 32'h77);
    for (int ep = 0; ep < 24; ep++) begin
      open_epoch($urandom);
      for (int k = $urandom_range(0, 20); k > 0; k--) begin
        if ($urandom_range(0, 3) == 0) begin
          step();
          chk("rnd_gap_spec", spec_active, 1);
        end else wr(5'($urandom), $urandom);
      end
      if ($urandom_range(0, 1) == 0) do_commit();
      else do_recover(1'($urandom), 1'($urandom), 5'($urandom), $urandom);
    end
    do_reset();
    check_idle("reset2");
    open_epoch(32'h0040_0700);
    for (int i = 1; i <= 4; i++) wr(5'(i + 10), 32'h40 + 32'(i));
    recover = 1;
    step();
    clear_in();
    chk("mid_r1_reg", rf_restore_reg, 14);
    step();
    chk("mid_r2_reg", rf_restore_reg, 13);
    rst_n = 0;
    step();
    rst_n = 1;
    q.delete();
    check_idle("mid_reset");
    for (int i = 0; i < 4; i++) begin
      step();
      check_idle("mid_after");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vp_recovery_unit.md
Name: vp_recovery_unit

Overview:
- Responder side of the load value-prediction recovery handshake.
- Opens a speculative epoch when the value predictor issues a first prediction, and logs the pre-write value of every register-file write during the epoch in an undo log.
- On a correct prediction (commit): discards the log.
- On a misprediction (recover): unwinds the log newest-first through a register-file restore port, then pulses recovery_done with the redirect PC.
- Sits between the value predictor, writeback stage and register file.

Parameters:
- LOG_DEPTH, 16, undo-log entries (power of 2, ≥2).
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 32, PC width.
- REG_IDX_WIDTH, 5, register index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- chk_start  in  1  first prediction issued; open epoch.
- chk_pc  in  ADDR_WIDTH  PC of predicted load, latched with chk_start.
- commit  in  1  prediction verified correct.
- recover  in  1  misprediction detected.
- wb_valid  in  1  register-file write this cycle.
- wb_reg  in  REG_IDX_WIDTH  write destination.
- wb_old_data  in  DATA_WIDTH  current contents of wb_reg (regfile read port).
- spec_active  out  1  epoch open (SPEC or UNWIND).
- log_full  out  1  log occupancy == LOG_DEPTH; writeback must stall.
- overflow_err  out  1  sticky: write arrived while full.
- rf_restore_en  out  1  restore write strobe.
- rf_restore_reg  out  REG_IDX_WIDTH  restore destination.
- rf_restore_data  out  DATA_WIDTH  restore value.
- recovery_done  out  1  one-cycle pulse; unwind complete.
- redirect_valid  out  1  same cycle as recovery_done.
- redirect_pc  out  ADDR_WIDTH  latched chk_pc.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, count=0, all outputs 0, overflow_err cleared. Reset mid-UNWIND abandons the unwind; no further restores.
- States: IDLE, SPEC, UNWIND, DONE. count is a ceil(log2(LOG_DEPTH))+1-bit log pointer (stack).
- IDLE:
  - chk_start → SPEC; latch chk_pc; count=0.
  - commit/recover/wb ignored.
- SPEC:
  - Push when wb_valid && wb_reg≠0 && count<LOG_DEPTH: entry[count]={wb_reg, wb_old_data}; count+1.
  - wb_valid when count==LOG_DEPTH: write not logged; overflow_err←1.
  - log_full combinational = (state==SPEC && count==LOG_DEPTH).
  - recover → UNWIND. A write in the same cycle is logged first, so it is undone.
  - commit (without recover) → IDLE; count←0.
  - recover && commit in the same cycle: recover wins.
  - chk_start in SPEC ignored.
- UNWIND:
  - Combinational: rf_restore_en=(count≠0); rf_restore_reg/data=entry[count-1]. count−1 per cycle.
  - count≤1 → DONE next cycle.
  - wb_valid, commit, recover and chk_start ignored.
- DONE (one cycle): recovery_done=1, redirect_valid=1, redirect_pc=latched chk_pc → IDLE. chk_start in DONE ignored.
- Latency: recover sampled at edge T with N logged entries, N≥1: restores in cycles T+1..T+N (newest first), recovery_done in T+N+1. N=0: no restore, recovery_done in T+2.
- rf_restore_* are 0 whenever rf_restore_en=0.
- spec_active=1 in SPEC and UNWIND, 0 in IDLE and DONE.
- overflow_err is cleared only by reset.

Optional Feature:
- Macro: VP_LOG_COALESCE_EN.
- Defined:
  - A 2^REG_IDX_WIDTH-bit logged mask, cleared on entering SPEC.
  - A write is pushed only if its mask bit is clear, then the bit is set. Repeat writes to the same register neither consume entries nor raise overflow_err.
  - Restore order is still newest-first.
- Undefined: every nonzero-register write is logged; no mask.

Test Plan:
- Commit path: chk_start with chk_pc=0x0040_0100; writes r3 (old 0x11), r4 (old 0x22); commit → count returns to 0, IDLE, no rf_restore_en, no recovery_done.
- Recover unwind: chk_pc=0x0040_0200; writes r5 (old 0xA), r6 (old 0xB), r5 (old 0xC); recover at T:
  - T+1: r5=0xC; T+2: r6=0xB; T+3: r5=0xA.
  - T+4: recovery_done=1, redirect_pc=0x0040_0200.
  - With VP_LOG_COALESCE_EN: T+1 r6=0xB, T+2 r5=0xA, recovery_done at T+3.
- Empty recover: chk_start, then recover with no writes → no restore strobes; recovery_done at T+2.
- Full/overflow: LOG_DEPTH=16; 16 writes to r1..r16 → log_full=1; 17th write → overflow_err=1 and sticky. Recover → 16 restores r16..r1, recovery_done at T+17.
- Simultaneous events:
  - commit && recover same cycle with 2 entries → unwind of 2 entries occurs.
  - wb_valid to r7 (old 0x77) in the recover cycle → first restore is r7=0x77.
  - wb_valid to r0 → never logged.
- Reset mid-unwind: 4 entries, recover, assert rst_n=0 after 2 restores → next cycle all outputs 0, IDLE; no recovery_done.
